// File: rtl/rs232_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the RS232 sequencer/arbiter.
package rs232_ctrl_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;

   typedef enum logic {
      T_ARB,
      T_XFER
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_HOLD
   } rx_state_t;

   // Width of an index into n requesters; never less than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
module rr_arbiter
   import rs232_ctrl_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = idx_w(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   // Scan requesters starting at the round-robin pointer, first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = IDX_W'((32'(ptr) + i) % NREQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/rs232_ctrl.sv
// Sequencer in front of one UART: packet-locked round-robin TX sharing and an RX buffer
// drain that walks the read address toward the UART's write pointer.
module rs232_ctrl
   import rs232_ctrl_pkg::*;
#(
   parameter int unsigned NREQ      = 2,   // 1..8
   parameter int unsigned RX_RD_LAT = 1,   // 0..3
   parameter int unsigned IDLE_TMO  = 255  // must be >= 1
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic [NREQ-1:0]        iReqValid,
   input  logic [DATA_W*NREQ-1:0] iReqData,
   input  logic [NREQ-1:0]        iReqLast,
   output logic [NREQ-1:0]        oReqReady,
   output logic [NREQ-1:0]        oGrant,
   output logic                   oTmo,
   output logic [DATA_W-1:0]      oTxData,
   output logic                   oTxWrite,
   input  logic                   iTxFull,
   output logic [ADDR_W-1:0]      oRxReadAddr,
   input  logic [ADDR_W-1:0]      iRxWrAddr,
   input  logic [DATA_W-1:0]      iRxData,
   output logic                   oRxValid,
   output logic [DATA_W-1:0]      oRxByte,
   input  logic                   iRxReady
);

   localparam int unsigned IDX_W = idx_w(NREQ);
   localparam int unsigned TMO_W = $clog2(IDLE_TMO + 1);
   localparam int unsigned LAT_W = 2;

   // ---------------------------------------------------------------- TX path
   tx_state_t        tx_state_q, tx_state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             tmo_q, tmo_d;

   logic [NREQ-1:0]   arb_grant;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_any;
   logic              cur_valid;
   logic              cur_last;
   logic [DATA_W-1:0] cur_data;
   logic [IDX_W-1:0]  gidx_next;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req   (iReqValid),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign cur_valid = iReqValid[gidx_q];
   assign cur_last  = iReqLast[gidx_q];
   assign cur_data  = iReqData[gidx_q*DATA_W +: DATA_W];
   assign gidx_next = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

   // TX next-state and the zero-latency write port towards the UART.
   always_comb begin
      tx_state_d = tx_state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      tmo_d      = 1'b0;
      oReqReady  = '0;
      oTxWrite   = 1'b0;
      oTxData    = '0;

      case (tx_state_q)
         T_ARB: begin
            if (arb_any) begin
               tx_state_d = T_XFER;
               grant_d    = arb_grant;
               gidx_d     = arb_idx;
               idle_cnt_d = '0;
            end
         end
         T_XFER: begin
            oReqReady = grant_q & {NREQ{!iTxFull}};
            oTxData   = cur_data;
            oTxWrite  = cur_valid & !iTxFull;
            if (cur_valid && !iTxFull) begin
               idle_cnt_d = '0;
               if (cur_last) begin
                  tx_state_d = T_ARB;
                  grant_d    = '0;
                  rr_ptr_d   = gidx_next;
               end
            end else if (!cur_valid && !iTxFull) begin
               // A full UART is a stall, not owner idleness, so only count here.
               if (idle_cnt_q == TMO_W'(IDLE_TMO - 1)) begin
                  tx_state_d = T_ARB;
                  grant_d    = '0;
                  rr_ptr_d   = gidx_next;
                  tmo_d      = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = T_ARB;
            grant_d    = '0;
         end
      endcase

      // Reset asserted mid-packet must not let a byte slip into the UART.
      if (!iRst) begin
         oReqReady = '0;
         oTxWrite  = 1'b0;
         oTxData   = '0;
      end
   end

   // TX state registers with synchronous active-low reset.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         tx_state_q <= T_ARB;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   assign oGrant = grant_q;
   assign oTmo   = tmo_q;

   // ---------------------------------------------------------------- RX path
   rx_state_t         rx_state_q, rx_state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
   logic              rx_valid_q, rx_valid_d;
   logic              pending;

   // Equal pointers read as empty, so a completely full buffer is invisible here.
   assign pending = (iRxWrAddr != rd_ptr_q);

   // RX next-state: wait out the read latency, capture, hold until accepted.
   always_comb begin
      rx_state_d = rx_state_q;
      rd_ptr_d   = rd_ptr_q;
      lat_cnt_d  = lat_cnt_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;

      case (rx_state_q)
         R_IDLE: begin
            if (pending) begin
               // The read address has already sat on rd_ptr for this cycle.
               if (RX_RD_LAT == 0) begin
                  rx_byte_d  = iRxData;
                  rx_valid_d = 1'b1;
                  rx_state_d = R_HOLD;
               end else begin
                  lat_cnt_d  = LAT_W'(1);
                  rx_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (lat_cnt_q == LAT_W'(RX_RD_LAT)) begin
               rx_byte_d  = iRxData;
               rx_valid_d = 1'b1;
               rx_state_d = R_HOLD;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         R_HOLD: begin
            if (iRxReady) begin
               rx_valid_d = 1'b0;
               rd_ptr_d   = rd_ptr_q + 1'b1;
               rx_state_d = R_IDLE;
            end
         end
         default: begin
            rx_state_d = R_IDLE;
            rx_valid_d = 1'b0;
         end
      endcase
   end

   // RX state registers with synchronous active-low reset.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         rx_state_q <= R_IDLE;
         rd_ptr_q   <= '0;
         lat_cnt_q  <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rd_ptr_q   <= rd_ptr_d;
         lat_cnt_q  <= lat_cnt_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign oRxReadAddr = rd_ptr_q;
   assign oRxValid    = rx_valid_q;
   assign oRxByte     = rx_byte_q;

endmodule
